// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: depth helper, read-mode
// encoding and threshold legality check used at elaboration.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int depth_of(input int add_width);
        return 1 << add_width;
    endfunction

    // almost_full must be reachable and nonzero; almost_empty must stay below depth.
    function automatic bit thr_legal(input int af_thr, input int ae_thr, input int depth);
        return (af_thr >= 1) && (af_thr <= depth) && (ae_thr >= 0) && (ae_thr <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// No reset, so stale contents survive reset and flush.
module fifo_mem #(
    parameter int data_width = 8,
    parameter int add_width  = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [add_width-1:0]  wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic [add_width-1:0]  rd_addr,
    output logic [data_width-1:0] rd_data
);

    logic [data_width-1:0] mem [2**add_width];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with exact count, programmable thresholds,
// standard or first-word-fall-through read mode, flush and sticky error flags.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int data_width = 8,
    parameter int add_width  = 4,
    parameter int fwft       = FIFO_STD,
    parameter int af_thr     = 14,
    parameter int ae_thr     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [data_width-1:0] data_in,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic [data_width-1:0] data_out,
    output logic                  data_valid,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [add_width:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int               DEPTH     = depth_of(add_width);
    localparam logic [add_width:0] DEPTH_LVL = (add_width + 1)'(DEPTH);
    localparam logic [add_width:0] AF_LVL    = (add_width + 1)'(af_thr);
    localparam logic [add_width:0] AE_LVL    = (add_width + 1)'(ae_thr);
    localparam logic [add_width:0] ONE       = (add_width + 1)'(1);

    if (!thr_legal(af_thr, ae_thr, DEPTH)) begin : g_bad_thr
        $error("sync_fifo_ctrl: af_thr/ae_thr out of range for depth %0d", DEPTH);
    end
    if (fwft != FIFO_STD && fwft != FIFO_FWFT) begin : g_bad_mode
        $error("sync_fifo_ctrl: fwft must be 0 or 1");
    end

    logic [add_width:0]    wr_ptr;
    logic [add_width:0]    rd_ptr;
    logic [data_width-1:0] rd_data;
    logic                  wr_acc;
    logic                  rd_acc;

    assign full         = (count == DEPTH_LVL);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    // Flush and reset both veto any access in their cycle, including the memory write.
    assign wr_acc = rst_n && !flush && wr_en && !full;
    assign rd_acc = rst_n && !flush && rd_en && !empty;

    fifo_mem #(
        .data_width (data_width),
        .add_width  (add_width)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[add_width-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr[add_width-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
            overflow  <= overflow  | (wr_en && full);
            underflow <= underflow | (rd_en && empty);
        end
    end

    if (fwft == FIFO_FWFT) begin : g_fwft
        assign data_out   = rd_data;
        assign data_valid = !empty;
    end else begin : g_std
        // Output register gives the one-cycle read latency of the standard mode.
        always_ff @(posedge clk) begin
            if (!rst_n || flush) begin
                data_out   <= '0;
                data_valid <= 1'b0;
            end else if (rd_acc) begin
                data_out   <= rd_data;
                data_valid <= 1'b1;
            end else begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: one standard-mode and one FWFT instance
// sharing clock and reset, with hand-computed expectations.
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       s_flush, s_wr_en, s_rd_en;
    logic [7:0] s_data_in, s_data_out;
    logic       s_full, s_almost_full, s_data_valid, s_empty, s_almost_empty;
    logic       s_overflow, s_underflow;
    logic [4:0] s_count;

    logic       f_flush, f_wr_en, f_rd_en;
    logic [7:0] f_data_in, f_data_out;
    logic       f_full, f_almost_full, f_data_valid, f_empty, f_almost_empty;
    logic       f_overflow, f_underflow;
    logic [4:0] f_count;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.data_width(8), .add_width(4), .fwft(0), .af_thr(14), .ae_thr(2)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(s_flush), .data_in(s_data_in), .wr_en(s_wr_en),
        .full(s_full), .almost_full(s_almost_full), .data_out(s_data_out),
        .data_valid(s_data_valid), .rd_en(s_rd_en), .empty(s_empty),
        .almost_empty(s_almost_empty), .count(s_count), .overflow(s_overflow),
        .underflow(s_underflow)
    );

    sync_fifo_ctrl #(.data_width(8), .add_width(4), .fwft(1), .af_thr(14), .ae_thr(2)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(f_flush), .data_in(f_data_in), .wr_en(f_wr_en),
        .full(f_full), .almost_full(f_almost_full), .data_out(f_data_out),
        .data_valid(f_data_valid), .rd_en(f_rd_en), .empty(f_empty),
        .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow),
        .underflow(f_underflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one clock edge on the selected instance, then returns inputs to idle.
    task automatic applyStimulus(input bit sel_fwft, input logic w, input logic [7:0] d,
                                 input logic r, input logic fl);
        if (sel_fwft) begin
            f_wr_en = w; f_data_in = d; f_rd_en = r; f_flush = fl;
        end else begin
            s_wr_en = w; s_data_in = d; s_rd_en = r; s_flush = fl;
        end
        @(posedge clk);
        #1;
        s_wr_en = 0; s_rd_en = 0; s_flush = 0;
        f_wr_en = 0; f_rd_en = 0; f_flush = 0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp;
        int         n_written;
        int         cyc;
        bit         w, r;

        s_wr_en = 0; s_rd_en = 0; s_flush = 0; s_data_in = 0;
        f_wr_en = 0; f_rd_en = 0; f_flush = 0; f_data_in = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;

        $display("[TB] reset state");
        checkOutput("rst_count", s_count, 0);
        checkOutput("rst_empty", s_empty, 1);
        checkOutput("rst_full", s_full, 0);
        checkOutput("rst_ae", s_almost_empty, 1);
        checkOutput("rst_af", s_almost_full, 0);
        checkOutput("rst_valid", s_data_valid, 0);
        checkOutput("rst_ovf", s_overflow, 0);
        checkOutput("rst_udf", s_underflow, 0);
        checkOutput("rst_fwft_valid", f_data_valid, 0);

        $display("[TB] fill 16 words");
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 1, 8'(i), 0, 0);
            checkOutput("fill_count", s_count, i);
            checkOutput("fill_ae", s_almost_empty, (i <= 2));
            checkOutput("fill_af", s_almost_full, (i >= 14));
            checkOutput("fill_full", s_full, (i == 16));
        end
        applyStimulus(0, 1, 8'hAA, 0, 0);
        checkOutput("ovf_count", s_count, 16);
        checkOutput("ovf_flag", s_overflow, 1);

        $display("[TB] drain 16 words");
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 0, 8'h00, 1, 0);
            checkOutput("drain_data", s_data_out, i);
            checkOutput("drain_valid", s_data_valid, 1);
            checkOutput("drain_count", s_count, 16 - i);
        end
        checkOutput("drain_empty", s_empty, 1);
        applyStimulus(0, 0, 8'h00, 1, 0);
        checkOutput("udf_flag", s_underflow, 1);
        checkOutput("udf_valid", s_data_valid, 0);
        checkOutput("udf_ovf_sticky", s_overflow, 1);

        $display("[TB] simultaneous read/write");
        applyStimulus(0, 0, 8'h00, 0, 1);
        checkOutput("flush_ovf", s_overflow, 0);
        checkOutput("flush_udf", s_underflow, 0);
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 8'(8'h20 + i), 0, 0);
        checkOutput("full_before_rw", s_full, 1);
        applyStimulus(0, 1, 8'hBB, 1, 0);
        checkOutput("rw_full_count", s_count, 15);
        checkOutput("rw_full_ovf", s_overflow, 1);
        checkOutput("rw_full_data", s_data_out, 8'h20);
        applyStimulus(0, 0, 8'h00, 0, 1);
        applyStimulus(0, 1, 8'h77, 1, 0);
        checkOutput("rw_empty_count", s_count, 1);
        checkOutput("rw_empty_udf", s_underflow, 1);
        checkOutput("rw_empty_valid", s_data_valid, 0);
        q = {8'h77};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 8'(8'h78 + i), 0, 0);
            q.push_back(8'(8'h78 + i));
        end
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 1, 8'(8'h80 + k), 1, 0);
            exp = q.pop_front();
            q.push_back(8'(8'h80 + k));
            checkOutput("rw5_data", s_data_out, exp);
            checkOutput("rw5_count", s_count, 5);
        end

        $display("[TB] wrap-around traffic");
        applyStimulus(0, 0, 8'h00, 0, 1);
        q.delete();
        n_written = 0;
        cyc = 0;
        while ((n_written < 40 || q.size() > 0) && cyc < 300) begin
            w = (n_written < 40) && (q.size() < 12);
            r = (n_written < 40) ? ((q.size() > 3) && (cyc % 3 != 0)) : (q.size() > 0);
            applyStimulus(0, w, 8'(n_written), r, 0);
            if (r) begin
                exp = q.pop_front();
                checkOutput("wrap_data", s_data_out, exp);
            end
            if (w) begin
                q.push_back(8'(n_written));
                n_written++;
            end
            checkOutput("wrap_count", s_count, q.size());
            cyc++;
        end
        checkOutput("wrap_done", (cyc < 300), 1);
        checkOutput("wrap_ovf", s_overflow, 0);
        checkOutput("wrap_udf", s_underflow, 0);

        $display("[TB] FWFT mode");
        applyStimulus(1, 1, 8'h5A, 0, 0);
        checkOutput("fwft_valid", f_data_valid, 1);
        checkOutput("fwft_data", f_data_out, 8'h5A);
        applyStimulus(1, 0, 8'h00, 1, 0);
        checkOutput("fwft_pop_valid", f_data_valid, 0);
        checkOutput("fwft_pop_empty", f_empty, 1);
        applyStimulus(1, 1, 8'hEE, 0, 1);
        checkOutput("fwft_flush_count", f_count, 0);
        checkOutput("fwft_flush_nowrite", f_data_out, 8'h5A);

        $display("[TB] flush at count 9");
        applyStimulus(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 17; i++) applyStimulus(0, 1, 8'(8'h90 + i), 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 8'h00, 1, 0);
        checkOutput("pre_flush_count", s_count, 9);
        checkOutput("pre_flush_ovf", s_overflow, 1);
        applyStimulus(0, 1, 8'hEE, 0, 1);
        checkOutput("flush_count", s_count, 0);
        checkOutput("flush_empty", s_empty, 1);
        checkOutput("flush_ovf9", s_overflow, 0);
        checkOutput("flush_valid", s_data_valid, 0);

        $display("[TB] reset mid-burst");
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 8'(8'hC0 + i), 0, 0);
        applyStimulus(0, 1, 8'hC5, 1, 0);
        checkOutput("burst_valid", s_data_valid, 1);
        rst_n = 0;
        applyStimulus(0, 1, 8'hC6, 1, 0);
        rst_n = 1;
        checkOutput("midrst_count", s_count, 0);
        checkOutput("midrst_empty", s_empty, 1);
        checkOutput("midrst_valid", s_data_valid, 0);
        checkOutput("midrst_data", s_data_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
